print_scheduler: RTL
====================

PRINT_SCHEDULER -- requirements
Module: print_scheduler

Interface
REQ-001 SHALL have port: clk  in  1  single system clock, all logic on rising edge.
REQ-002 SHALL have port: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have port: req  in  1  print request strobe from game logic.
REQ-004 SHALL have port: board_in  in  320  live board, 16 cells x 20 bits, cell k at [20k +: 20].
REQ-005 SHALL have port: score_in  in  21  live score.
REQ-006 SHALL have ports: bts_board  out  320  and  bts_score  out  21, the snapshot driven to board_to_string.
REQ-007 SHALL have ports: bts_start  out  1, bts_print_nxt  out  1, bts_char  in  8, bts_done  in  1, the board_to_string handshake.
REQ-008 SHALL have ports: tx_data  out  8, tx_valid  out  1, tx_ready  in  1, the UART transmitter valid/ready interface.
REQ-009 SHALL have ports: busy  out  1, pending  out  1, overrun  out  1 (sticky), frames_sent  out  16.
REQ-010 SHALL have parameter MAX_CHARS, default 2047, the per-frame character limit.

Function
REQ-011 SHALL implement states IDLE, START, ARM, FETCH, LATCH, SEND, FINISH.
REQ-012 IDLE: on req or pending, SHALL capture board_in/score_in into bts_board/bts_score, clear pending and go to START; busy=0 only in IDLE.
REQ-013 START: SHALL assert bts_start for exactly one cycle, clear char_cnt to 0, go to ARM.
REQ-014 ARM: SHALL wait one cycle without sampling bts_done, then go to FETCH.
REQ-015 FETCH: if bts_done=1, SHALL go to FINISH; else if char_cnt==MAX_CHARS, SHALL set overrun and go to FINISH; else SHALL pulse bts_print_nxt for one cycle and go to LATCH.
REQ-016 LATCH: SHALL register bts_char into tx_data (valid the cycle after the print_nxt pulse), increment char_cnt and go to SEND.
REQ-017 SEND: SHALL hold tx_valid=1 with tx_data stable until tx_ready=1; on handshake SHALL go to FETCH; tx_valid SHALL be 0 in all other states.
REQ-018 FINISH: SHALL increment frames_sent (wraps 0xFFFF->0) and return to IDLE; overrun frames SHALL also count.
REQ-019 req while busy SHALL set pending; multiple requests SHALL coalesce into one; req in the same cycle as FINISH SHALL set pending.
REQ-020 bts_board/bts_score SHALL remain constant from leaving IDLE until re-entering IDLE, regardless of board_in changes.
REQ-021 Frame latency: bts_start SHALL assert 1 cycle after req sampled in IDLE; the first tx_valid SHALL assert 4 cycles after bts_start.
REQ-022 char_cnt SHALL be 11 bits; it SHALL saturate at MAX_CHARS and never wrap.

Reset
REQ-023 rst SHALL force state IDLE; bts_start, bts_print_nxt, tx_valid, busy, pending and overrun SHALL be 0; tx_data, bts_board, bts_score, char_cnt and frames_sent SHALL be 0.
REQ-024 rst mid-frame SHALL abort the frame on the next edge; a handshake in flight is dropped and frames_sent is not incremented.
REQ-025 rst SHALL take priority over req in the same cycle.

Structure
REQ-026 A shared package SHALL hold the state enum, BOARD_W=320, CELL_W=20, SCORE_W=21, CHAR_W=8 and MAX_CHARS default.
REQ-027 The block SHALL be one module with no sub-modules; board_to_string and the UART SHALL be instantiated by the parent.

Verification
REQ-028 req pulse, model emits "2048\n" (5 chars) then done, tx_ready tied 1 -> exactly 5 tx handshakes in order, frames_sent=1, busy low after FINISH.
REQ-029 tx_ready held 0 for 10 cycles on char 2 -> tx_valid held high, tx_data unchanged, no extra bts_print_nxt pulses.
REQ-030 three req pulses during one frame -> pending=1, exactly one further frame, frames_sent=2.
REQ-031 board_in cell 4 changed 1234->5678 mid-frame -> bts_board[80 +: 20] stays 1234 until IDLE.
REQ-032 model never asserts done, MAX_CHARS=8 -> 8 chars sent, overrun=1, frames_sent=1, return to IDLE.
REQ-033 rst asserted in SEND -> next cycle state IDLE, tx_valid=0, pending=0, frames_sent unchanged at 0.

Source files
------------

// File: rtl/print_scheduler_pkg.sv
// print_scheduler_pkg
//   Shared widths, the frame-sequencer state encoding and the default
//   per-frame character limit for print_scheduler and its parent.
//
//   Board layout: 16 cells of CELL_W bits each. Cell k occupies
//   bits [CELL_W*k +: CELL_W] of a BOARD_W-bit vector.
package print_scheduler_pkg;

  localparam int BOARD_W           = 320;
  localparam int CELL_W            = 20;
  localparam int NUM_CELLS         = BOARD_W / CELL_W;
  localparam int SCORE_W           = 21;
  localparam int CHAR_W            = 8;
  localparam int CNT_W             = 11;
  localparam int FRAME_CNT_W       = 16;
  localparam int MAX_CHARS_DEFAULT = 2047;

  // Frame sequencer states. The numeric encoding is what dbg_state_o
  // shows, so it is pinned explicitly.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_ARM    = 3'd2,
    S_FETCH  = 3'd3,
    S_LATCH  = 3'd4,
    S_SEND   = 3'd5,
    S_FINISH = 3'd6
  } state_e;

  // Offset of a board cell inside the packed board vector.
  function automatic int cell_lsb(input int k);
    return k * CELL_W;
  endfunction

endpackage

// File: rtl/print_scheduler.sv
// print_scheduler
//   Turns a print request from the game logic into one text frame on a
//   UART. On a request the live board and score are snapshotted, the
//   external board_to_string formatter is started, and its characters are
//   pulled one at a time (bts_print_nxt -> bts_char) and handed to the
//   UART transmitter until the formatter reports done or the per-frame
//   character limit is reached.
//
// Ports
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   req            print request strobe
//   board_in       live board (16 x 20-bit cells)
//   score_in       live score
//   bts_board      board snapshot held for the whole frame
//   bts_score      score snapshot held for the whole frame
//   bts_start      one-cycle start pulse to board_to_string
//   bts_print_nxt  one-cycle "give me the next character" pulse
//   bts_char       character returned the cycle after bts_print_nxt
//   bts_done       formatter has no more characters
//   tx_data        character to transmit
//   tx_valid       tx_data is valid
//   tx_ready       UART accepts tx_data this cycle
//   busy           a frame is in progress (low only in IDLE)
//   pending        a request arrived while busy; another frame will follow
//   overrun        sticky: a frame was truncated at MAX_CHARS
//   frames_sent    completed frames, wraps at 16 bits
//   dbg_state_o    current sequencer state (state_e encoding)
//
// Handshake: a character transfers on a rising edge where tx_valid and
// tx_ready are both 1. Once tx_valid rises it stays high and tx_data stays
// unchanged until that transfer; tx_valid never depends on tx_ready.
module print_scheduler
  import print_scheduler_pkg::*;
#(
  parameter int MAX_CHARS = MAX_CHARS_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req,
  input  logic [BOARD_W-1:0]     board_in,
  input  logic [SCORE_W-1:0]     score_in,
  output logic [BOARD_W-1:0]     bts_board,
  output logic [SCORE_W-1:0]     bts_score,
  output logic                   bts_start,
  output logic                   bts_print_nxt,
  input  logic [CHAR_W-1:0]      bts_char,
  input  logic                   bts_done,
  output logic [CHAR_W-1:0]      tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   busy,
  output logic                   pending,
  output logic                   overrun,
  output logic [FRAME_CNT_W-1:0] frames_sent,
  output logic [2:0]             dbg_state_o
);

  // The character counter is CNT_W bits wide, so the limit is clipped to it.
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CHARS);

  state_e                 state_q, state_d;
  logic [BOARD_W-1:0]     board_q, board_d;
  logic [SCORE_W-1:0]     score_q, score_d;
  logic                   pending_q, pending_d;
  logic                   overrun_q, overrun_d;
  logic [CHAR_W-1:0]      tx_data_q, tx_data_d;
  logic [CNT_W-1:0]       char_cnt_q, char_cnt_d;
  logic [FRAME_CNT_W-1:0] frames_q, frames_d;

  logic launch;    // leave IDLE this cycle
  logic at_limit;  // frame already carries MAX_CHARS characters

  assign launch   = (state_q == S_IDLE) && (req || pending_q);
  assign at_limit = (char_cnt_q == MAX_CNT);

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (launch) state_d = S_START;
      S_START:  state_d = S_ARM;
      // ARM gives the formatter one cycle to react to bts_start, so a
      // bts_done left over from the previous frame is never mistaken
      // for the end of this one.
      S_ARM:    state_d = S_FETCH;
      S_FETCH: begin
        if (bts_done || at_limit) state_d = S_FINISH;
        else                      state_d = S_LATCH;
      end
      S_LATCH:  state_d = S_SEND;
      S_SEND:   if (tx_ready) state_d = S_FETCH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    bts_start     = 1'b0;
    bts_print_nxt = 1'b0;
    tx_valid      = 1'b0;
    busy          = 1'b1;
    unique case (state_q)
      S_IDLE:  busy = 1'b0;
      S_START: bts_start = 1'b1;
      S_FETCH: bts_print_nxt = !bts_done && !at_limit;
      S_SEND:  tx_valid = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------
  always_comb begin
    board_d    = board_q;
    score_d    = score_q;
    pending_d  = pending_q;
    overrun_d  = overrun_q;
    tx_data_d  = tx_data_q;
    char_cnt_d = char_cnt_q;
    frames_d   = frames_q;

    // Snapshot is only taken on the way out of IDLE, so it stays frozen
    // for the whole frame whatever board_in does.
    if (launch) begin
      board_d = board_in;
      score_d = score_in;
    end

    // Any number of requests while busy (including during FINISH) fold
    // into one follow-up frame. IDLE always consumes pending: either it
    // launches on it or it was already clear.
    if (state_q == S_IDLE) begin
      pending_d = 1'b0;
    end else if (req) begin
      pending_d = 1'b1;
    end

    if ((state_q == S_FETCH) && !bts_done && at_limit) begin
      overrun_d = 1'b1;
    end

    if (state_q == S_START) begin
      char_cnt_d = '0;
    end else if ((state_q == S_LATCH) && !at_limit) begin
      char_cnt_d = char_cnt_q + 1'b1;
    end

    // bts_char is valid the cycle after bts_print_nxt, which is LATCH.
    if (state_q == S_LATCH) begin
      tx_data_d = bts_char;
    end

    if (state_q == S_FINISH) begin
      frames_d = frames_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      board_q    <= '0;
      score_q    <= '0;
      pending_q  <= 1'b0;
      overrun_q  <= 1'b0;
      tx_data_q  <= '0;
      char_cnt_q <= '0;
      frames_q   <= '0;
    end else begin
      board_q    <= board_d;
      score_q    <= score_d;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      tx_data_q  <= tx_data_d;
      char_cnt_q <= char_cnt_d;
      frames_q   <= frames_d;
    end
  end

  assign bts_board   = board_q;
  assign bts_score   = score_q;
  assign tx_data     = tx_data_q;
  assign pending     = pending_q;
  assign overrun     = overrun_q;
  assign frames_sent = frames_q;
  assign dbg_state_o = state_q;

endmodule
